// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared defaults and types for the hazard scoreboard unit.
//   HZ_REG_ADDR_W / HZ_NUM_REGS : register file geometry
//   HZ_DIV_LAT                  : divider occupancy in cycles (>= 2)
//   hazard_cause_e              : which priority level is driving the pipeline controls
package hazard_scoreboard_unit_pkg;

   localparam int HZ_REG_ADDR_W = 5;
   localparam int HZ_NUM_REGS   = 32;
   localparam int HZ_DIV_LAT    = 8;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_MEM    = 2'd1,
      CAUSE_BRANCH = 2'd2,
      CAUSE_USE    = 2'd3
   } hazard_cause_e;

   function automatic int cnt_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : the pipeline (drives stage info, receives stall/flush controls)
//   slave  : the hazard unit
interface hazard_scoreboard_unit_if #(
   parameter int REG_ADDR_W = hazard_scoreboard_unit_pkg::HZ_REG_ADDR_W,
   parameter int NUM_REGS   = hazard_scoreboard_unit_pkg::HZ_NUM_REGS
);
   logic [REG_ADDR_W-1:0] Rs1D, Rs2D, RdD, RDE, RDW;
   logic                  UsesRs1D, UsesRs2D, LongD, IsDivD;
   logic                  RegWriteE, MemReadE, DivE, PCSrcE;
   logic                  MemReqM, MemReadyM;
   logic                  RegWriteW, LongW;
   logic                  StallF, StallD, StallE, StallM;
   logic                  FlushD, FlushE, FlushW;
   logic                  DivBusy;
   logic [NUM_REGS-1:0]   PendingMask;

   modport master (
      output Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, LongD, IsDivD,
      output RDE, RegWriteE, MemReadE, DivE, PCSrcE,
      output MemReqM, MemReadyM, RDW, RegWriteW, LongW,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  DivBusy, PendingMask
   );

   modport slave (
      input  Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, LongD, IsDivD,
      input  RDE, RegWriteE, MemReadE, DivE, PCSrcE,
      input  MemReqM, MemReadyM, RDW, RegWriteW, LongW,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output DivBusy, PendingMask
   );
endinterface

// File: rtl/hazard_scoreboard_unit_scoreboard.sv
// Pending-bit array for long-latency register writers.
//   set_en/set_idx : mark a register as having an outstanding long write
//   clr_en/clr_idx : long write retired in W
//   mask_o         : current pending bits (bit 0 always 0)
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_idx,
   output logic [NUM_REGS-1:0]   mask_o
);

   logic [NUM_REGS-1:0] pend_q, pend_d;

   // Set is applied after clear so a newer writer of the same register wins.
   always_comb begin
      pend_d = pend_q;
      if (clr_en) pend_d[clr_idx] = 1'b0;
      if (set_en) pend_d[set_idx] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   assign mask_o = pend_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage core: scoreboard for loads/divides, divider busy counter,
// and fixed-priority stall/flush generation (memory wait > taken branch > use stall).
//   clk, rst_n : clock, async active-low reset
//   hz (slave) : stage inputs, stall/flush outputs, DivBusy, PendingMask
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = HZ_REG_ADDR_W,
   parameter int NUM_REGS   = HZ_NUM_REGS,
   parameter int DIV_LAT    = HZ_DIV_LAT
) (
   input logic                     clk,
   input logic                     rst_n,
   hazard_scoreboard_unit_if.slave hz
);

   localparam int CNT_W = cnt_width(DIV_LAT);

   logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
   logic [NUM_REGS-1:0] pend_mask;
   logic [NUM_REGS-1:0] busy_vec;
   logic                mem_stall, e_long, clr_en, issue;
   logic                raw_stall, div_stall, div_busy;
   hazard_cause_e       cause;

   assign mem_stall = hz.MemReqM & ~hz.MemReadyM;
   assign e_long    = hz.RegWriteE & (hz.MemReadE | hz.DivE);
   assign clr_en    = hz.RegWriteW & hz.LongW;
   assign issue     = e_long & (hz.RDE != '0) & ~mem_stall;
   assign div_busy  = (div_cnt_q != '0);

   hazard_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_REGS   (NUM_REGS)
   ) u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (issue),
      .set_idx (hz.RDE),
      .clr_en  (clr_en),
      .clr_idx (hz.RDW),
      .mask_o  (pend_mask)
   );

   // A register retiring in W this cycle is forwarded, so it no longer blocks D.
   always_comb begin
      busy_vec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         busy_vec[r] = (pend_mask[r] & ~(clr_en & (hz.RDW == REG_ADDR_W'(r))))
                     | (e_long & (hz.RDE == REG_ADDR_W'(r)));
      end
   end

   assign raw_stall = (hz.UsesRs1D & busy_vec[hz.Rs1D])
                    | (hz.UsesRs2D & busy_vec[hz.Rs2D])
                    | (hz.LongD    & busy_vec[hz.RdD]);
   assign div_stall = hz.IsDivD & (div_busy | hz.DivE);

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (hz.DivE && !mem_stall) div_cnt_d = CNT_W'(DIV_LAT - 1);
      else if (div_busy)         div_cnt_d = div_cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_cnt_q <= '0;
      else        div_cnt_q <= div_cnt_d;
   end

   always_comb begin
      if (mem_stall)                   cause = CAUSE_MEM;
      else if (hz.PCSrcE)              cause = CAUSE_BRANCH;
      else if (raw_stall | div_stall)  cause = CAUSE_USE;
      else                             cause = CAUSE_NONE;
   end

   // During a memory wait the branch stays in E and is re-evaluated, so no flush yet.
   always_comb begin
      hz.StallF = 1'b0;
      hz.StallD = 1'b0;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b0;
      unique case (cause)
         CAUSE_MEM: begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
         end
         CAUSE_BRANCH: begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
         end
         CAUSE_USE: begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
         end
         default: ;
      endcase
   end

   assign hz.DivBusy     = div_busy;
   assign hz.PendingMask = pend_mask;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;
   import hazard_scoreboard_unit_pkg::*;

   localparam logic [6:0] CTL_NONE = 7'h00;
   localparam logic [6:0] CTL_USE  = 7'h62;
   localparam logic [6:0] CTL_MEM  = 7'h79;
   localparam logic [6:0] CTL_BR   = 7'h06;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errs;
   int   stall_cnt;

   hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .NUM_REGS(32)) hz ();

   hazard_scoreboard_unit #(.REG_ADDR_W(5), .NUM_REGS(32), .DIV_LAT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] ctl();
      return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
   endfunction

   task automatic idle_inputs();
      hz.Rs1D = '0; hz.Rs2D = '0; hz.RdD = '0; hz.RDE = '0; hz.RDW = '0;
      hz.UsesRs1D = 0; hz.UsesRs2D = 0; hz.LongD = 0; hz.IsDivD = 0;
      hz.RegWriteE = 0; hz.MemReadE = 0; hz.DivE = 0; hz.PCSrcE = 0;
      hz.MemReqM = 0; hz.MemReadyM = 0; hz.RegWriteW = 0; hz.LongW = 0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic e_load(input logic [4:0] rd);
      hz.RegWriteE = 1; hz.MemReadE = 1; hz.RDE = rd;
   endtask

   task automatic w_long(input logic [4:0] rd);
      hz.RegWriteW = 1; hz.LongW = 1; hz.RDW = rd;
   endtask

   task automatic d_div();
      hz.IsDivD = 1; hz.LongD = 1; hz.RdD = 5'd8;
   endtask

   initial begin
      n_checks = 0;
      n_errs   = 0;
      rst_n    = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctl", 32'(ctl()), 32'(CTL_NONE));
      check("rst_mask", hz.PendingMask, 32'h0);
      check("rst_divbusy", 32'(hz.DivBusy), 32'h0);
      rst_n = 1'b1;

      // load-use on x5
      next_cyc(); e_load(5'd5); hz.UsesRs1D = 1; hz.Rs1D = 5'd5;
      @(negedge clk);
      check("lu_e_stage", 32'(ctl()), 32'(CTL_USE));
      next_cyc(); hz.UsesRs2D = 1; hz.Rs2D = 5'd5;
      @(negedge clk);
      check("lu_pending_mask", hz.PendingMask, 32'h0000_0020);
      check("lu_pending_rs2", 32'(ctl()), 32'(CTL_USE));
      next_cyc(); hz.UsesRs1D = 1; hz.Rs1D = 5'd5; w_long(5'd5);
      @(negedge clk);
      check("lu_clear_cycle", 32'(ctl()), 32'(CTL_NONE));
      next_cyc();
      @(negedge clk);
      check("lu_cleared_mask", hz.PendingMask, 32'h0);

      // divide x7 with another divide waiting in D
      next_cyc(); hz.RegWriteE = 1; hz.DivE = 1; hz.RDE = 5'd7; d_div();
      @(negedge clk);
      check("div_first_ctl", 32'(ctl()), 32'(CTL_USE));
      check("div_first_busy", 32'(hz.DivBusy), 32'h0);
      stall_cnt = hz.StallD ? 1 : 0;
      for (int k = 0; k < 20; k++) begin
         next_cyc(); d_div();
         @(negedge clk);
         if (!hz.StallD) break;
         stall_cnt++;
      end
      check("div_stall_cycles", 32'(stall_cnt), 32'd8);
      check("div_busy_done", 32'(hz.DivBusy), 32'h0);
      check("div_mask_x7", hz.PendingMask, 32'h0000_0080);
      next_cyc(); hz.UsesRs1D = 1; hz.Rs1D = 5'd7;
      @(negedge clk);
      check("div_user_stall", 32'(ctl()), 32'(CTL_USE));
      check("div_cnt_saturated", 32'(hz.DivBusy), 32'h0);
      next_cyc(); hz.UsesRs1D = 1; hz.Rs1D = 5'd7; w_long(5'd7);
      @(negedge clk);
      check("div_user_clear", 32'(ctl()), 32'(CTL_NONE));
      next_cyc();
      @(negedge clk);
      check("div_mask_clear", hz.PendingMask, 32'h0);

      // memory wait with a concurrent taken branch; divide in E must not issue
      for (int k = 0; k < 3; k++) begin
         next_cyc();
         hz.MemReqM = 1; hz.MemReadyM = 0; hz.PCSrcE = 1;
         hz.RegWriteE = 1; hz.DivE = 1; hz.RDE = 5'd10;
         @(negedge clk);
         check($sformatf("mem_wait_%0d", k), 32'(ctl()), 32'(CTL_MEM));
      end
      next_cyc(); hz.MemReqM = 1; hz.MemReadyM = 1; hz.PCSrcE = 1;
      @(negedge clk);
      check("mem_release_branch", 32'(ctl()), 32'(CTL_BR));
      check("mem_no_issue_mask", hz.PendingMask, 32'h0);
      check("mem_no_div_load", 32'(hz.DivBusy), 32'h0);

      // x9: WAW, branch over use-stall, same-cycle set/clear, no-op clear
      next_cyc(); e_load(5'd9);
      @(negedge clk);
      next_cyc(); hz.LongD = 1; hz.RdD = 5'd9;
      @(negedge clk);
      check("x9_mask", hz.PendingMask, 32'h0000_0200);
      check("x9_waw_stall", 32'(ctl()), 32'(CTL_USE));
      next_cyc(); hz.UsesRs1D = 1; hz.Rs1D = 5'd9; hz.PCSrcE = 1;
      e_load(5'd9); w_long(5'd9);
      @(negedge clk);
      check("x9_branch_wins", 32'(ctl()), 32'(CTL_BR));
      next_cyc();
      @(negedge clk);
      check("x9_set_wins", hz.PendingMask, 32'h0000_0200);
      next_cyc(); w_long(5'd9);
      @(negedge clk);
      next_cyc(); w_long(5'd3);
      @(negedge clk);
      check("x9_cleared", hz.PendingMask, 32'h0);
      next_cyc();
      @(negedge clk);
      check("noop_clear", hz.PendingMask, 32'h0);

      // x0 is never tracked
      next_cyc(); e_load(5'd0); hz.UsesRs1D = 1; hz.Rs1D = 5'd0;
      @(negedge clk);
      check("x0_no_stall", 32'(ctl()), 32'(CTL_NONE));
      next_cyc(); hz.UsesRs1D = 1; hz.Rs1D = 5'd0;
      @(negedge clk);
      check("x0_mask", hz.PendingMask, 32'h0);

      // asynchronous reset mid-divide with x5 pending
      next_cyc(); hz.RegWriteE = 1; hz.DivE = 1; hz.RDE = 5'd0;
      @(negedge clk);
      next_cyc(); e_load(5'd5);
      @(negedge clk);
      next_cyc();
      @(negedge clk);
      check("pre_rst_mask", hz.PendingMask, 32'h0000_0020);
      check("pre_rst_busy", 32'(hz.DivBusy), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_mask", hz.PendingMask, 32'h0);
      check("async_rst_busy", 32'(hz.DivBusy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cyc();
      @(negedge clk);
      check("post_rst_ctl", 32'(ctl()), 32'(CTL_NONE));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
